// File: rtl/sd_cmd_framer_if.sv
// Command hand-off bus between the SD command framer and the command decoder.
// The framer drives a held {index, argument} under cmd_valid; the decoder answers with cmd_ack.
interface sd_cmd_framer_if;
    logic        cmd_valid;
    logic        cmd_ack;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    // Framer side
    modport master (
        output cmd_valid,
        output cmd_index,
        output cmd_arg,
        input  cmd_ack
    );

    // Decoder side
    modport slave (
        input  cmd_valid,
        input  cmd_index,
        input  cmd_arg,
        output cmd_ack
    );
endinterface

// File: rtl/sd_cmd_framer.sv
// SD-mode SPI command framer.
// Assembles 6-byte command frames (start byte, 32-bit argument, CRC7 + end bit) from the
// deserializer byte stream, checks them, and holds good commands for the decoder until acked.
module sd_cmd_framer #(
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   CS,
    input  logic [7:0]             ByteIn,
    input  logic                   ByteChanged,
    sd_cmd_framer_if.master        cmd,
    output logic                   crc_error,
    output logic                   frame_error,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        StIdle,
        StArg,
        StCrc
    } state_e;

    state_e      state_q, state_d;
    logic        bc_q, bc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] shift_q, shift_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic strobe;
    logic ack_take;
    logic hold_pending;

    // CRC7, polynomial x^7 + x^3 + 1, one byte MSB first
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    // One strobe per rising edge of the deserializer completion flag
    assign strobe   = ByteChanged & ~bc_q;
    assign ack_take = cmd_valid_q & cmd.cmd_ack;
    // A finished frame must be dropped if the previous command is still held and not taken now
    assign hold_pending = cmd_valid_q & ~cmd.cmd_ack;

    // Frame parsing, checking and command hand-off
    always_comb begin
        state_d     = state_q;
        bc_d        = ByteChanged;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        index_d     = index_q;
        shift_d     = shift_q;
        cmd_valid_d = cmd_valid_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (ack_take) begin
            cmd_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (CS) begin
            // Deselect drops any partial frame but leaves a held command alone
            state_d = StIdle;
            cnt_d   = 2'd0;
            crc_d   = 7'd0;
        end else if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (ByteIn[7:6] == 2'b01) begin
                        index_d = ByteIn[5:0];
                        crc_d   = crc7_byte(7'd0, ByteIn);
                        cnt_d   = 2'd0;
                        state_d = StArg;
                        if (hold_pending) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                StArg: begin
                    shift_d = {shift_q[23:0], ByteIn};
                    crc_d   = crc7_byte(crc_q, ByteIn);
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StCrc;
                    end
                end
                StCrc: begin
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                    crc_d   = 7'd0;
                    if (!hold_pending) begin
                        if (!ByteIn[0]) begin
                            frame_err_d = 1'b1;
                        end else if (CHECK_CRC && (ByteIn[7:1] != crc_q)) begin
                            crc_err_d = 1'b1;
                        end else begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = index_q;
                            cmd_arg_d   = shift_q;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bc_q        <= 1'b0;
            cnt_q       <= 2'd0;
            crc_q       <= 7'd0;
            index_q     <= 6'd0;
            shift_q     <= 32'd0;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_index = cmd_index_q;
    assign cmd.cmd_arg   = cmd_arg_q;
    assign crc_error     = crc_err_q;
    assign frame_error   = frame_err_q;
    assign overrun       = overrun_q;

endmodule
